bus_arb: RTL and testbench

- Two-master arbiter that shares one downstream memory/peripheral request port.
- Master 0 is the CPU bus interface; master 1 is a second bus master (DMA/video fetch).
- Request, write-data and read-data streams use the same protocol on every side: req_valid/req_ready handshake, len/mask/addr/we, write_valid beats, read_valid/read_ack beats.
- A grant is held for a whole transaction, including every data beat of a burst.

---
 rtl/bus_arb.sv | 155 +++++++++++++++
 tb/tb_bus_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb.sv
// Two-master burst arbiter: 1-cycle request latency, grant held for the whole burst, loser stalls with req_ready=0.
// Define BUS_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 wins ties.
module bus_arb #(
  parameter int MAX_LEN = 4,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [2:0]        m0_req_len,
  input  logic [3:0]        m0_req_mask,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic              m0_req_we,
  input  logic              m0_write_valid,
  input  logic [31:0]       m0_write_data,
  output logic              m0_read_valid,
  output logic [31:0]       m0_read_data,
  input  logic              m0_read_ack,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [2:0]        m1_req_len,
  input  logic [3:0]        m1_req_mask,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic              m1_req_we,
  input  logic              m1_write_valid,
  input  logic [31:0]       m1_write_data,
  output logic              m1_read_valid,
  output logic [31:0]       m1_read_data,
  input  logic              m1_read_ack,
  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [2:0]        s_req_len,
  output logic [3:0]        s_req_mask,
  output logic [ADDR_W-1:0] s_req_addr,
  output logic              s_req_we,
  output logic              s_write_valid,
  output logic [31:0]       s_write_data,
  input  logic              s_read_valid,
  input  logic [31:0]       s_read_data,
  output logic              s_read_ack,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  localparam logic [2:0] MAX_L = 3'(MAX_LEN);

  state_t              state_q;
  logic [1:0]          grant_q;
  logic                busy_q;
  logic [2:0]          beats_q;
  logic                s_req_valid_q;
  logic [2:0]          s_req_len_q;
  logic [3:0]          s_req_mask_q;
  logic [ADDR_W-1:0]   s_req_addr_q;
  logic                s_req_we_q;

  logic                sel1;
  logic [2:0]          win_len;
  logic [2:0]          eff_len;
  logic                hs;
  logic                wr_phase;
  logic                rd_phase;

`ifdef BUS_ARB_RR_EN
  logic last_owner_q;
  // Ties go to whichever master did not own the previous transaction.
  assign sel1 = m1_req_valid & (~m0_req_valid | ~last_owner_q);
`else
  assign sel1 = m1_req_valid & ~m0_req_valid;
`endif

  assign win_len = sel1 ? m1_req_len : m0_req_len;
  assign eff_len = (win_len == 3'd0) ? 3'd1 : ((win_len > MAX_L) ? MAX_L : win_len);

  assign hs       = s_req_valid_q & s_req_ready;
  assign wr_phase = (state_q == WDATA);
  assign rd_phase = (state_q == RDATA);

  assign m0_req_ready  = grant_q[0] & hs;
  assign m1_req_ready  = grant_q[1] & hs;
  assign s_write_valid = wr_phase & ((grant_q[0] & m0_write_valid) | (grant_q[1] & m1_write_valid));
  assign s_write_data  = grant_q[1] ? m1_write_data : m0_write_data;
  assign m0_read_valid = rd_phase & grant_q[0] & s_read_valid;
  assign m1_read_valid = rd_phase & grant_q[1] & s_read_valid;
  assign m0_read_data  = s_read_data;
  assign m1_read_data  = s_read_data;
  assign s_read_ack    = rd_phase & ((grant_q[0] & m0_read_ack) | (grant_q[1] & m1_read_ack));

  assign s_req_valid = s_req_valid_q;
  assign s_req_len   = s_req_len_q;
  assign s_req_mask  = s_req_mask_q;
  assign s_req_addr  = s_req_addr_q;
  assign s_req_we    = s_req_we_q;
  assign grant       = grant_q;
  assign busy        = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      busy_q        <= 1'b0;
      beats_q       <= 3'd0;
      s_req_valid_q <= 1'b0;
      s_req_len_q   <= 3'd0;
      s_req_mask_q  <= 4'd0;
      s_req_addr_q  <= '0;
      s_req_we_q    <= 1'b0;
`ifdef BUS_ARB_RR_EN
      last_owner_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req_valid | m1_req_valid) begin
            state_q       <= REQ;
            busy_q        <= 1'b1;
            grant_q       <= sel1 ? 2'b10 : 2'b01;
            s_req_valid_q <= 1'b1;
            s_req_len_q   <= eff_len;
            s_req_mask_q  <= sel1 ? m1_req_mask : m0_req_mask;
            s_req_addr_q  <= sel1 ? m1_req_addr : m0_req_addr;
            s_req_we_q    <= sel1 ? m1_req_we : m0_req_we;
`ifdef BUS_ARB_RR_EN
            last_owner_q  <= sel1;
`endif
          end
        end
        REQ: begin
          if (hs) begin
            s_req_valid_q <= 1'b0;
            beats_q       <= s_req_len_q;
            state_q       <= s_req_we_q ? WDATA : RDATA;
          end
        end
        WDATA, RDATA: begin
          if (s_write_valid | (s_read_valid & s_read_ack)) begin
            if (beats_q == 3'd1) begin
              state_q <= IDLE;
              grant_q <= 2'b00;
              busy_q  <= 1'b0;
              beats_q <= 3'd0;
            end else begin
              beats_q <= beats_q - 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: table of transactions plus hand-written arbitration, stall and reset sequences.
module tb_bus_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_write_valid, m0_read_valid, m0_read_ack;
  logic [2:0]  m0_req_len;
  logic [3:0]  m0_req_mask;
  logic [31:0] m0_req_addr, m0_write_data, m0_read_data;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_write_valid, m1_read_valid, m1_read_ack;
  logic [2:0]  m1_req_len;
  logic [3:0]  m1_req_mask;
  logic [31:0] m1_req_addr, m1_write_data, m1_read_data;
  logic        s_req_valid, s_req_ready, s_req_we, s_write_valid, s_read_valid, s_read_ack;
  logic [2:0]  s_req_len;
  logic [3:0]  s_req_mask;
  logic [31:0] s_req_addr, s_write_data, s_read_data;
  logic [1:0]  grant;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  bus_arb #(.MAX_LEN(4), .ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_len(m0_req_len),
    .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr), .m0_req_we(m0_req_we),
    .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
    .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data), .m0_read_ack(m0_read_ack),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_len(m1_req_len),
    .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr), .m1_req_we(m1_req_we),
    .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
    .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data), .m1_read_ack(m1_read_ack),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_len(s_req_len),
    .s_req_mask(s_req_mask), .s_req_addr(s_req_addr), .s_req_we(s_req_we),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data),
    .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(s_read_ack),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    int         m;
    logic       we;
    logic [2:0] len;
    logic [31:0] addr;
    logic [3:0] mask;
    logic [2:0] exp_beats;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_req(input int m, input logic v, input logic we, input logic [2:0] len,
                         input logic [31:0] addr, input logic [3:0] mask);
    if (m == 0) begin
      m0_req_valid = v; m0_req_we = we; m0_req_len = len; m0_req_addr = addr; m0_req_mask = mask;
    end else begin
      m1_req_valid = v; m1_req_we = we; m1_req_len = len; m1_req_addr = addr; m1_req_mask = mask;
    end
  endtask

  task automatic set_wr(input int m, input logic v, input logic [31:0] d);
    if (m == 0) begin m0_write_valid = v; m0_write_data = d; end
    else        begin m1_write_valid = v; m1_write_data = d; end
  endtask

  task automatic set_ack(input int m, input logic v);
    if (m == 0) m0_read_ack = v; else m1_read_ack = v;
  endtask

  function automatic logic req_rdy(input int m);
    return (m == 0) ? m0_req_ready : m1_req_ready;
  endfunction

  function automatic logic rd_vld(input int m);
    return (m == 0) ? m0_read_valid : m1_read_valid;
  endfunction

  function automatic logic [31:0] rd_dat(input int m);
    return (m == 0) ? m0_read_data : m1_read_data;
  endfunction

  task automatic clear_inputs();
    set_req(0, 0, 0, 3'd0, 32'h0, 4'h0);
    set_req(1, 0, 0, 3'd0, 32'h0, 4'h0);
    set_wr(0, 0, 32'h0); set_wr(1, 0, 32'h0);
    set_ack(0, 0); set_ack(1, 0);
    s_read_valid = 1'b0; s_read_data = 32'h0; s_req_ready = 1'b1;
  endtask

  // Full transaction with s_req_ready high; checks latency, handshake pulse and exact beat count.
  task automatic do_txn(input txn_t t);
    logic [1:0] oh;
    oh = (t.m == 1) ? 2'b10 : 2'b01;
    set_req(t.m, 1'b1, t.we, t.len, t.addr, t.mask);
    #1;
    chk("pre_s_req_valid", s_req_valid, 0);
    chk("pre_grant", grant, 0);
    step();
    chk("grant", grant, oh);
    chk("s_req_valid", s_req_valid, 1);
    chk("busy", busy, 1);
    chk("s_req_len", s_req_len, t.exp_beats);
    chk("s_req_addr", s_req_addr, t.addr);
    chk("s_req_mask", s_req_mask, t.mask);
    chk("s_req_we", s_req_we, t.we);
    chk("req_ready_hs", req_rdy(t.m), 1);
    chk("req_ready_other", req_rdy(1 - t.m), 0);
    step();
    set_req(t.m, 1'b0, t.we, t.len, t.addr, t.mask);
    #1;
    chk("req_ready_pulse", req_rdy(t.m), 0);
    chk("s_req_valid_drop", s_req_valid, 0);
    for (int b = 0; b < int'(t.exp_beats); b++) begin
      chk("beat_grant", grant, oh);
      if (t.we) begin
        set_wr(t.m, 1'b1, 32'hD000_0000 + b);
        #1;
        chk("s_write_valid", s_write_valid, 1);
        chk("s_write_data", s_write_data, 32'hD000_0000 + b);
      end else begin
        s_read_valid = 1'b1; s_read_data = 32'hA0 + b; set_ack(t.m, 1'b1);
        #1;
        chk("rd_valid", rd_vld(t.m), 1);
        chk("rd_valid_other", rd_vld(1 - t.m), 0);
        chk("rd_data", rd_dat(t.m), 32'hA0 + b);
        chk("s_read_ack", s_read_ack, 1);
      end
      step();
    end
    set_wr(t.m, 1'b0, 32'h0); s_read_valid = 1'b0; set_ack(t.m, 1'b0);
    #1;
    chk("end_grant", grant, 0);
    chk("end_busy", busy, 0);
    chk("end_s_write_valid", s_write_valid, 0);
  endtask

  txn_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int win, lose;
    logic [1:0] win_oh, lose_oh;

    tbl[0] = '{m: 0, we: 1'b1, len: 3'd1, addr: 32'h4000_0010, mask: 4'b1111, exp_beats: 3'd1};
    tbl[1] = '{m: 1, we: 1'b0, len: 3'd4, addr: 32'h8000_0000, mask: 4'b0011, exp_beats: 3'd4};
    tbl[2] = '{m: 0, we: 1'b1, len: 3'd0, addr: 32'h0000_1234, mask: 4'b0001, exp_beats: 3'd1};
    tbl[3] = '{m: 1, we: 1'b1, len: 3'd7, addr: 32'h1111_2220, mask: 4'b1100, exp_beats: 3'd4};
    tbl[4] = '{m: 0, we: 1'b0, len: 3'd3, addr: 32'hCAFE_0000, mask: 4'b1010, exp_beats: 3'd3};
    tbl[5] = '{m: 1, we: 1'b0, len: 3'd0, addr: 32'h0BAD_F00C, mask: 4'b0101, exp_beats: 3'd1};

    clear_inputs();
    rst_i = 1'b1;
    m0_write_valid = 1'b1;
    step(); step();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_req_valid", s_req_valid, 0);
    chk("rst_s_req_len", s_req_len, 0);
    chk("rst_s_req_addr", s_req_addr, 0);
    chk("rst_s_req_mask", s_req_mask, 0);
    chk("rst_s_req_we", s_req_we, 0);
    chk("rst_s_write_valid", s_write_valid, 0);
    chk("rst_m0_req_ready", m0_req_ready, 0);
    m0_write_valid = 1'b0;
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      do_txn(tbl[i]);
      step();
    end

    // Arbitration: reset, one m0 transaction, then a simultaneous pair.
    rst_i = 1'b1; step(); rst_i = 1'b0; step();
    do_txn(tbl[0]);
    step();
`ifdef BUS_ARB_RR_EN
    win = 1;
`else
    win = 0;
`endif
    lose = 1 - win;
    win_oh  = (win == 1) ? 2'b10 : 2'b01;
    lose_oh = (lose == 1) ? 2'b10 : 2'b01;
    set_req(win, 1'b1, 1'b1, 3'd1, 32'h0000_AAA0, 4'hF);
    set_req(lose, 1'b1, 1'b1, 3'd1, 32'h0000_BBB0, 4'hF);
    step();
    chk("arb_grant_win", grant, win_oh);
    chk("arb_addr_win", s_req_addr, 32'h0000_AAA0);
    chk("arb_lose_ready", req_rdy(lose), 0);
    step();
    set_req(win, 1'b0, 1'b1, 3'd1, 32'h0000_AAA0, 4'hF);
    set_wr(win, 1'b1, 32'h1234_5678);
    set_wr(lose, 1'b1, 32'hDEAD_BEEF);
    #1;
    chk("arb_wdata_win", s_write_data, 32'h1234_5678);
    chk("arb_lose_ready_w", req_rdy(lose), 0);
    step();
    set_wr(win, 1'b0, 32'h0);
    set_wr(lose, 1'b0, 32'h0);
    #1;
    chk("arb_idle_gap", grant, 0);
    step();
    chk("arb_grant_lose", grant, lose_oh);
    chk("arb_addr_lose", s_req_addr, 32'h0000_BBB0);
    chk("arb_lose_hs", req_rdy(lose), 1);
    step();
    set_req(lose, 1'b0, 1'b1, 3'd1, 32'h0000_BBB0, 4'hF);
    set_wr(lose, 1'b1, 32'h0000_5555);
    #1;
    chk("arb_lose_wdata", s_write_data, 32'h0000_5555);
    step();
    set_wr(lose, 1'b0, 32'h0);
    #1;
    chk("arb_done_grant", grant, 0);
    step();

    // Downstream stall: request fields must hold while s_req_ready is low.
    s_req_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, 3'd2, 32'h5000_0040, 4'b0110);
    step();
    m1_req_addr = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_s_req_valid", s_req_valid, 1);
      chk("stall_s_req_addr", s_req_addr, 32'h5000_0040);
      chk("stall_s_req_len", s_req_len, 2);
      chk("stall_req_ready", m1_req_ready, 0);
      step();
    end
    s_req_ready = 1'b1;
    #1;
    chk("stall_release_ready", m1_req_ready, 1);
    step();
    set_req(1, 1'b0, 1'b0, 3'd2, 32'h0, 4'h0);
    for (int b = 0; b < 2; b++) begin
      s_read_valid = 1'b1; s_read_data = 32'hC0 + b; m1_read_ack = 1'b1;
      #1;
      chk("stall_rd_data", m1_read_data, 32'hC0 + b);
      chk("stall_m0_rd_valid", m0_read_valid, 0);
      step();
    end
    s_read_valid = 1'b0; m1_read_ack = 1'b0;
    #1;
    chk("stall_end_grant", grant, 0);
    step();

    // Reset during beat 2 of a 4-beat read.
    set_req(0, 1'b1, 1'b0, 3'd4, 32'h7000_0000, 4'hF);
    step(); step();
    set_req(0, 1'b0, 1'b0, 3'd4, 32'h7000_0000, 4'hF);
    s_read_valid = 1'b1; s_read_data = 32'hA0; m0_read_ack = 1'b1;
    step();
    s_read_data = 32'hA1;
    rst_i = 1'b1;
    step();
    #1;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_req_valid", s_req_valid, 0);
    chk("mid_rst_s_read_ack", s_read_ack, 0);
    chk("mid_rst_m0_read_valid", m0_read_valid, 0);
    rst_i = 1'b0;
    clear_inputs();
    step();
    #1;
    chk("post_rst_grant", grant, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
